// File: rtl/matrix_load_sequencer_pkg.sv
// Shared widths, sel codes and FSM state encoding for the matrix load sequencer.
package matrix_pkg;
  localparam int DATA_W   = 32;
  localparam int SEL_W    = 6;
  localparam int NUM_ELEM = 18;
  localparam int CMD_SEL  = 18;
  localparam int IDLE_SEL = 63;
  localparam int IDX_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    LOAD
  } state_e;
endpackage

// File: rtl/matrix_load_sequencer_fifo.sv
// Element buffer for the load sequencer: synchronous FIFO with flush,
// full/empty/count status and async active-low reset of the control state.
module seq_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Flush wins over both ports so a push coinciding with it is dropped.
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (PTR_W+1)'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/matrix_load_sequencer.sv
// Feeds the ALU matrix sel/eleIn pair: a command slot carrying op, then one
// slot per buffered element, each slot held for HOLD cycles.
module matrix_load_sequencer
  import matrix_pkg::*;
#(
  parameter int HOLD       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] eleIn,
  output logic              busy,
  output logic              done
);
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] ele_q, ele_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              run_q;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count_unused;

  // run_q keeps in_ready low until the first clock edge after reset release.
  assign in_ready  = run_q & ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  assign sel   = sel_q;
  assign eleIn = ele_q;
  assign busy  = busy_q;
  assign done  = done_q;

  seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (abort),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    sel_d    = sel_q;
    ele_d    = ele_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      hold_d  = '0;
      sel_d   = SEL_W'(IDLE_SEL);
      ele_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CMD;
            sel_d   = SEL_W'(CMD_SEL);
            ele_d   = op;
            hold_d  = HOLD_W'(HOLD - 1);
          end
        end
        CMD: begin
          if (hold_q == '0) begin
            state_d = WAIT;
            idx_d   = '0;
            sel_d   = SEL_W'(IDLE_SEL);
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        WAIT: begin
          // Pop now; the element is registered onto eleIn with its sel.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = LOAD;
            sel_d    = SEL_W'(idx_q);
            ele_d    = fifo_rdata;
            hold_d   = HOLD_W'(HOLD - 1);
          end
        end
        LOAD: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else if (idx_q == IDX_W'(NUM_ELEM - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
            sel_d   = SEL_W'(IDLE_SEL);
            ele_d   = '0;
          end else begin
            state_d = WAIT;
            idx_d   = idx_q + IDX_W'(1);
            sel_d   = SEL_W'(IDLE_SEL);
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = SEL_W'(IDLE_SEL);
          ele_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      sel_q   <= SEL_W'(IDLE_SEL);
      ele_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      ele_q   <= ele_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      run_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer: reset, nominal, backpressure,
// starved input, ignored start and abort scenarios.
module tb_matrix_load_sequencer;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, abort, in_valid, in_ready, busy, done;
  logic [31:0] op, in_data, eleIn;
  logic [5:0]  sel;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] feed_q[$];
  logic [31:0] exp_q[$];
  int          gap = 0;
  int          gap_cnt = 0;

  matrix_load_sequencer #(.HOLD(2), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
    .eleIn    (eleIn),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: offer the head of feed_q (respecting gap), then step to edge+1.
  task automatic tick();
    logic acc;
    if (feed_q.size() != 0 && gap_cnt == 0) begin
      in_valid = 1'b1;
      in_data  = feed_q[0];
    end else begin
      in_valid = 1'b0;
    end
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      void'(feed_q.pop_front());
      gap_cnt = gap;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
  endtask

  task automatic run_seq(input logic [31:0] op_v, input bit inject, input bit check_total);
    int cyc;
    int b;
    start = 1'b1;
    op    = op_v;
    tick();
    start = 1'b0;
    cyc   = 1;
    check("cmd_sel_0", 32'(sel), 18);
    check("cmd_ele_0", eleIn, op_v);
    check("cmd_busy", 32'(busy), 1);
    if (inject) begin
      start = 1'b1;
      op    = 32'd99;
    end
    tick();
    start = 1'b0;
    cyc++;
    check("cmd_sel_1", 32'(sel), 18);
    check("cmd_ele_1", eleIn, op_v);
    tick();
    cyc++;
    for (int k = 0; k < NUM_ELEM; k++) begin
      b = 0;
      while (sel === 6'd63 && b < 400) begin
        tick();
        cyc++;
        b++;
      end
      check("slot_done_low", 32'(done), 0);
      check("slot_sel_a", 32'(sel), k);
      check("slot_ele_a", eleIn, exp_q[k]);
      tick();
      cyc++;
      check("slot_sel_b", 32'(sel), k);
      check("slot_ele_b", eleIn, exp_q[k]);
      tick();
      cyc++;
    end
    check("done_pulse", 32'(done), 1);
    check("done_sel", 32'(sel), 63);
    check("done_ele", eleIn, 0);
    check("done_busy", 32'(busy), 0);
    if (check_total) check("start_to_done", cyc, 57);
    tick();
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int b;
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    op       = '0;
    in_data  = '0;

    #22;
    check("rst_sel", 32'(sel), 63);
    check("rst_ele", eleIn, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    #28;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a sequence
    for (int i = 0; i < 9; i++) feed_q.push_back(32'(i));
    repeat (6) tick();
    start = 1'b1;
    op    = 32'd30;
    tick();
    start = 1'b0;
    b = 0;
    while (sel !== 6'd5 && b < 200) begin
      tick();
      b++;
    end
    check("mid_reach_idx5", 32'(sel), 5);
    reset = 1'b0;
    #1;
    check("mid_rst_sel", 32'(sel), 63);
    check("mid_rst_ele", eleIn, 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    feed_q.delete();
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_count", 32'(dut.u_fifo.count_q), 0);
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Nominal with backpressure and an ignored start during CMD
    exp_q.delete();
    for (int i = 0; i < 18; i++) exp_q.push_back(32'(i % 9));
    for (int i = 0; i < 18; i++) feed_q.push_back(32'(i % 9));
    feed_q.push_back(32'd100);
    feed_q.push_back(32'd101);
    repeat (8) tick();
    check("bp_in_ready_low", 32'(in_ready), 0);
    check("bp_accepted", 32'(feed_q.size()), 16);
    run_seq(32'd30, 1'b1, 1'b1);
    check("extras_kept", 32'(dut.u_fifo.count_q), 2);

    // Starved input: two leftovers, then one element every 10 cycles
    exp_q.delete();
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd101);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'(200 + i));
      feed_q.push_back(32'(200 + i));
    end
    gap     = 9;
    gap_cnt = 9;
    run_seq(32'd5, 1'b0, 1'b0);
    gap     = 0;
    gap_cnt = 0;

    // Abort while loading element 7, then replay from CMD
    for (int i = 0; i < 18; i++) feed_q.push_back(32'(300 + i));
    repeat (4) tick();
    start = 1'b1;
    op    = 32'd30;
    tick();
    start = 1'b0;
    b = 0;
    while (sel !== 6'd7 && b < 200) begin
      tick();
      b++;
    end
    check("abort_reach_idx7", 32'(sel), 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_sel", 32'(sel), 63);
    check("abort_ele", eleIn, 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_count", 32'(dut.u_fifo.count_q), 0);
    feed_q.delete();
    tick();
    check("abort_no_done", 32'(done), 0);
    start = 1'b1;
    op    = 32'd31;
    tick();
    start = 1'b0;
    check("replay_sel", 32'(sel), 18);
    check("replay_ele", eleIn, 31);
    check("replay_busy", 32'(busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
